// File: rtl/logic_shift_unit.sv
// Registered logic/shift execution unit with valid/ready handshakes; shifts step one bit per cycle.
// Optional rotate opcodes (11 ROL, 12 ROR) are enabled by defining LSU_ROTATE_EN.
module logic_shift_unit #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_reg;
  logic [3:0]       op_reg;
  logic [WIDTH-1:0] work_reg;
  logic [WIDTH-1:0] result_reg;
  logic [SHW-1:0]   count_reg;
  logic             out_valid_reg;
  logic             err_reg;

  logic [WIDTH-1:0] gate_result;
  logic [WIDTH-1:0] shift_next;
  logic             is_gate;
  logic             is_shift;

  always_comb begin
    gate_result = '0;
    case (op)
      4'd0:    gate_result = a & b;
      4'd1:    gate_result = a | b;
      4'd2:    gate_result = a ^ b;
      4'd3:    gate_result = ~(a & b);
      4'd4:    gate_result = ~(a | b);
      4'd5:    gate_result = ~(a ^ b);
      4'd6:    gate_result = ~a;
      4'd7:    gate_result = a;
      default: gate_result = '0;
    endcase
  end

  assign is_gate = (op <= 4'd7);

`ifdef LSU_ROTATE_EN
  assign is_shift = (op >= 4'd8) && (op <= 4'd12);
`else
  assign is_shift = (op >= 4'd8) && (op <= 4'd10);
`endif

  // One-bit step of the working register in the direction of the captured opcode.
  always_comb begin
    shift_next = work_reg;
    case (op_reg)
      4'd8:    shift_next = {work_reg[WIDTH-2:0], 1'b0};
      4'd9:    shift_next = {1'b0, work_reg[WIDTH-1:1]};
      4'd10:   shift_next = {work_reg[WIDTH-1], work_reg[WIDTH-1:1]};
`ifdef LSU_ROTATE_EN
      4'd11:   shift_next = {work_reg[WIDTH-2:0], work_reg[WIDTH-1]};
      4'd12:   shift_next = {work_reg[0], work_reg[WIDTH-1:1]};
`endif
      default: shift_next = work_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      op_reg        <= '0;
      work_reg      <= '0;
      result_reg    <= '0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            op_reg <= op;
            if (is_gate) begin
              result_reg <= gate_result;
              err_reg    <= 1'b0;
              state_reg  <= DONE;
            end else if (is_shift) begin
              work_reg  <= a;
              count_reg <= shamt;
              state_reg <= BUSY;
            end else begin
              result_reg <= '0;
              err_reg    <= 1'b1;
              state_reg  <= DONE;
            end
          end
        end
        BUSY: begin
          if (count_reg == '0) begin
            result_reg <= work_reg;
            err_reg    <= 1'b0;
            state_reg  <= DONE;
          end else begin
            work_reg  <= shift_next;
            count_reg <= count_reg - 1'b1;
          end
        end
        DONE: begin
          // out_valid rises one cycle after entering DONE, then holds until the handoff.
          if (!out_valid_reg) begin
            out_valid_reg <= 1'b1;
          end else if (out_ready) begin
            out_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_logic_shift_unit.sv
// Directed self-checking bench for logic_shift_unit at WIDTH=8; rotate expectations follow LSU_ROTATE_EN.
module tb_logic_shift_unit;

  localparam int WIDTH = 8;
  localparam int SHW   = $clog2(WIDTH);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             err;

  int n_cmp;
  int n_bad;

  logic_shift_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request, measure latency, optionally stall in DONE, then hand off.
  task automatic do_req(input string tag, input logic [3:0] op_i, input logic [7:0] a_i,
                        input logic [7:0] b_i, input logic [2:0] sh_i,
                        input logic [7:0] exp_res, input logic exp_err,
                        input int exp_lat, input int hold);
    int lat;
    check({tag, ".in_ready_pre"}, in_ready, 1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    op = op_i; a = a_i; b = b_i; shamt = sh_i;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = ~op_i; a = ~a_i; b = ~b_i; shamt = ~sh_i;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".result"}, result, exp_res);
    check({tag, ".err"}, err, exp_err);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ".stall_valid"}, out_valid, 1);
      check({tag, ".stall_result"}, result, exp_res);
      check({tag, ".stall_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, ".post_in_ready"}, in_ready, 1);
    check({tag, ".post_valid"}, out_valid, 0);
    check({tag, ".post_err"}, err, 0);
    $display("txn %s op=%0d a=%02h b=%02h sh=%0d -> res=%02h err=%0b lat=%0d", tag, op_i, a_i, b_i, sh_i, exp_res, exp_err, lat);
  endtask

  logic [7:0] gate_exp [8];

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; a = '0; b = '0; shamt = '0;
    gate_exp[0] = 8'h88; gate_exp[1] = 8'hEE; gate_exp[2] = 8'h66; gate_exp[3] = 8'h77;
    gate_exp[4] = 8'h11; gate_exp[5] = 8'h99; gate_exp[6] = 8'h33; gate_exp[7] = 8'hCC;

    repeat (2) @(posedge clk);
    #1;
    check("reset.in_ready", in_ready, 1);
    check("reset.out_valid", out_valid, 0);
    check("reset.result", result, 0);
    check("reset.err", err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++)
      do_req($sformatf("gate%0d", i), 4'(i), 8'hCC, 8'hAA, 3'd0, gate_exp[i], 1'b0, 1, 0);

    do_req("shl3", 4'd8, 8'h96, 8'h00, 3'd3, 8'hB0, 1'b0, 5, 0);
    do_req("shr3", 4'd9, 8'h96, 8'h00, 3'd3, 8'h12, 1'b0, 5, 0);
    do_req("sra3", 4'd10, 8'h96, 8'h00, 3'd3, 8'hF2, 1'b0, 5, 0);
    do_req("shl0", 4'd8, 8'h96, 8'h00, 3'd0, 8'h96, 1'b0, 2, 0);
    do_req("sra7", 4'd10, 8'h80, 8'h00, 3'd7, 8'hFF, 1'b0, 9, 0);

`ifdef LSU_ROTATE_EN
    do_req("rol1", 4'd11, 8'h81, 8'h00, 3'd1, 8'h03, 1'b0, 3, 0);
    do_req("ror1", 4'd12, 8'h81, 8'h00, 3'd1, 8'hC0, 1'b0, 3, 0);
`else
    do_req("rol1", 4'd11, 8'h81, 8'h00, 3'd1, 8'h00, 1'b1, 1, 0);
    do_req("ror1", 4'd12, 8'h81, 8'h00, 3'd1, 8'h00, 1'b1, 1, 0);
`endif

    do_req("illegal15", 4'd15, 8'h5A, 8'hA5, 3'd2, 8'h00, 1'b1, 1, 0);
    do_req("stall_xor", 4'd2, 8'h3C, 8'h0F, 3'd0, 8'h33, 1'b0, 1, 10);

    // Reset pulse while a long shift is in BUSY.
    in_valid = 1'b1; op = 4'd8; a = 8'hFF; b = 8'h00; shamt = 3'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid.in_ready_busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid.out_valid", out_valid, 0);
    check("rst_mid.result", result, 0);
    check("rst_mid.in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("txn rst_mid shl sh=7 aborted by reset");
    do_req("after_rst_and", 4'd0, 8'hF0, 8'h3C, 3'd0, 8'h30, 1'b0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
